// File: rtl/fifo_stream_out_pkg.sv
// Shared skid-occupancy type and the room test used by the FIFO drain pop rule.
package fifo_stream_out_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // A full skid only has room when its head is leaving this same cycle.
  function automatic logic skid_has_room(input occ_t occ, input logic ready);
    return (occ != OCC_FULL) || ready;
  endfunction

endpackage

// File: rtl/fifo_stream_out_skid.sv
// Two-entry register skid buffer: push into the tail, pop from slot0, 1-cycle push-to-head.
// slot0 is only rewritten when it is popped, so a stalled head stays stable.
module stream_skid2
  import fifo_stream_out_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  occ_t                  occ_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= OCC_EMPTY;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      occ_r <= OCC_EMPTY;
    end else begin
      case (occ_r)
        OCC_EMPTY: begin
          if (push) begin
            slot0 <= push_data;
            occ_r <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            slot0 <= push_data;
          end else if (push) begin
            slot1 <= push_data;
            occ_r <= OCC_FULL;
          end else if (pop) begin
            occ_r <= OCC_EMPTY;
          end
        end
        default: begin
          // Full: a push is only ever offered together with a pop.
          if (pop) begin
            slot0 <= slot1;
            if (push) begin
              slot1 <= push_data;
            end else begin
              occ_r <= OCC_ONE;
            end
          end
        end
      endcase
    end
  end

  assign occ  = occ_r;
  assign head = slot0;

endmodule

// File: rtl/fifo_stream_out.sv
// Drains a first-word-fall-through BRAM FIFO into a valid/ready stream with TLAST framing.
// Head word appears on m_valid 1 cycle after its pop; the skid sustains 1 beat/clk under backpressure.
module fifo_stream_out
  import fifo_stream_out_pkg::*;
#(
  parameter  int DATA_WIDTH   = 16,
  parameter  int PACKET_WORDS = 8,
  localparam int CNT_WIDTH    = $clog2(PACKET_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(PACKET_WORDS - 1);

  logic empty_q;
  occ_t occ;
  logic xfer;
  logic last_beat;

  // BRAM read-after-write settle: the first non-empty cycle is never a pop cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      empty_q <= 1'b1;
    end else begin
      empty_q <= fifo_empty;
    end
  end

  assign fifo_rd_en = ~rst & ~fifo_empty & ~empty_q & skid_has_room(occ, m_ready) & ~flush;

  assign m_valid   = (occ != OCC_EMPTY) & ~flush;
  assign xfer      = m_valid & m_ready;
  assign last_beat = (beat_count == LAST_IDX);
  assign m_last    = m_valid & last_beat;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      beat_count <= '0;
    end else if (xfer) begin
      beat_count <= last_beat ? '0 : beat_count + CNT_WIDTH'(1);
    end
  end

  stream_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fifo_rd_en),
    .push_data (fifo_rd_data),
    .pop       (xfer),
    .occ       (occ),
    .head      (m_data)
  );

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: behavioural FWFT FIFO feeding the DUT, expected beats queued at write time.
module tb_fifo_stream_out;

  localparam int DW = 16;
  localparam int PW = 8;
  localparam int CW = $clog2(PW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          flush;
  logic [CW-1:0] beat_count;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         sb[$];
  beat_t         exp_b;
  logic [DW-1:0] fifo_q[$];
  logic          wr_en;
  logic [DW-1:0] wr_data;
  int n_cmp = 0;
  int n_bad = 0;
  int push_idx = 0;
  int xfer_cnt = 0;
  int empty_pop_viol = 0;

  always #5 clk = ~clk;

  fifo_stream_out #(
    .DATA_WIDTH   (DW),
    .PACKET_WORDS (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .flush        (flush),
    .beat_count   (beat_count)
  );

  // FWFT FIFO model: pop and write at the edge, flags visible after it.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_empty || fifo_q.size() == 0) empty_pop_viol++;
      else void'(fifo_q.pop_front());
    end
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty   <= (fifo_q.size() == 0);
    fifo_rd_data <= (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      xfer_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_data);
      end else begin
        exp_b = sb.pop_front();
        check("beat_data", 32'(m_data), 32'(exp_b.data));
        check("beat_last", 32'(m_last), 32'(exp_b.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    sb.push_back(beat_t'{data: d, last: ((push_idx % PW) == PW - 1)});
    push_idx++;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || m_valid || fifo_q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n >= 1000) begin
      n_bad++;
      $display("FAIL %s_drain: %0d beats still pending, expected 0", name, sb.size());
    end
  endtask

  task automatic write_block(input logic [DW-1:0] base_d, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      write_word(base_d + DW'(i));
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Stream exactly three beats of five words, then stall so the last two sit in the skid.
  task automatic send_three(input logic [DW-1:0] base_d, input string name);
    int base = xfer_cnt;
    int n = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      write_word(base_d + DW'(i));
      tick();
      if (xfer_cnt - base >= 3) m_ready = 1'b0;
    end
    wr_en = 1'b0;
    while (!((xfer_cnt - base >= 3) && fifo_q.size() == 0) && n < 50) begin
      tick();
      n++;
      if (xfer_cnt - base >= 3) m_ready = 1'b0;
    end
    repeat (2) tick();
    check({name, "_sent3"}, 32'(xfer_cnt - base), 32'd3);
    check({name, "_skid_valid"}, 32'(m_valid), 32'd1);
  endtask

  initial begin
    int pops;
    int hold_bad;
    int n;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_count", 32'(beat_count), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

    // 1: eight words, one full packet, latency from empty falling
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      write_word(DW'(i + 1));
      tick();
      if (i == 0) check("t1_no_pop_settle", 32'(fifo_rd_en), 32'd0);
      if (i == 1) begin
        check("t1_pop_second", 32'(fifo_rd_en), 32'd1);
        check("t1_valid_early", 32'(m_valid), 32'd0);
      end
      if (i == 2) begin
        check("t1_first_valid", 32'(m_valid), 32'd1);
        check("t1_first_data", 32'(m_data), 32'h0001);
      end
    end
    wr_en = 1'b0;
    wait_drain("t1");

    // 3: random backpressure over 64 words
    for (int i = 0; i < 64; i++) begin
      write_word(DW'(16'h0100 + i));
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    m_ready = 1'b1;
    wait_drain("t3");
    check("t3_pop_while_empty", 32'(empty_pop_viol), 32'd0);

    // 5: flush with two words in the skid mid-packet
    send_three(16'h00B0, "t5");
    check("t5_count_pre", 32'(beat_count), 32'd3);
    flush = 1'b1;
    #1;
    check("t5_valid_in_flush", 32'(m_valid), 32'd0);
    check("t5_rd_en_in_flush", 32'(fifo_rd_en), 32'd0);
    sb.delete();
    push_idx = 0;
    tick();
    flush = 1'b0;
    check("t5_valid_after", 32'(m_valid), 32'd0);
    check("t5_count_after", 32'(beat_count), 32'd0);
    m_ready = 1'b1;
    write_block(16'h00C0, 8);
    wait_drain("t5");

    // 4: single word into an empty FIFO
    write_word(16'h0055);
    tick();
    wr_en = 1'b0;
    check("t4_no_pop_on_fall", 32'(fifo_rd_en), 32'd0);
    tick();
    check("t4_pop_next", 32'(fifo_rd_en), 32'd1);
    wait_drain("t4");

    // 6: reset mid-packet with a full, stalled skid
    send_three(16'h00D0, "t6");
    check("t6_count_pre", 32'(beat_count), 32'd4);
    rst = 1'b1;
    sb.delete();
    push_idx = 0;
    tick();
    rst = 1'b0;
    check("t6_valid", 32'(m_valid), 32'd0);
    check("t6_last", 32'(m_last), 32'd0);
    check("t6_data", 32'(m_data), 32'd0);
    check("t6_count", 32'(beat_count), 32'd0);
    check("t6_rd_en", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    write_block(16'h00E0, 8);
    wait_drain("t6");

    // 2: backpressure stalls after two pops; head holds until release
    m_ready = 1'b0;
    pops = 0;
    hold_bad = 0;
    for (int i = 0; i < 4; i++) begin
      write_word(DW'(16'h00A0 + i));
      tick();
      if (fifo_rd_en) pops++;
    end
    wr_en = 1'b0;
    repeat (5) begin
      tick();
      if (fifo_rd_en) pops++;
      if (!m_valid || m_data !== 16'h00A0) hold_bad++;
    end
    check("t2_pops", 32'(pops), 32'd2);
    check("t2_hold_stable", 32'(hold_bad), 32'd0);
    m_ready = 1'b1;
    wait_drain("t2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
